// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared constants and BCD helpers for bcd_stopwatch
package stopwatch_pkg;

    localparam int DIGIT_W      = 4;
    localparam int SEC_ONES_MOD = 10;
    localparam int SEC_TENS_MOD = 6;
    localparam int MIN_MOD      = 10;

    localparam logic MODE_UP = 1'b0;
    localparam logic MODE_DN = 1'b1;

    // Digit 1 is the seconds-tens digit; every other position is decimal.
    function automatic int digit_mod(input int idx);
        if (idx == 0) return SEC_ONES_MOD;
        if (idx == 1) return SEC_TENS_MOD;
        return MIN_MOD;
    endfunction

    function automatic logic bcd_word_valid(input logic [63:0] word, input int n_digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i < n_digits) begin
                if (word[i*DIGIT_W +: DIGIT_W] > 4'(digit_mod(i) - 1)) ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// rtl/bcd_digit_cnt.sv - one modulo-MOD BCD digit with carry/borrow outputs
module bcd_digit_cnt #(
    parameter int MOD = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       en,
    input  logic       dn,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic       carry_out,
    output logic       borrow_out
);

    localparam logic [3:0] MAX = 4'(MOD - 1);

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            q <= 4'd0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            if (dn) q <= (q == 4'd0) ? MAX : q - 4'd1;
            else    q <= (q == MAX) ? 4'd0 : q + 4'd1;
        end
    end

    // Carry/borrow are qualified by en so the next digit steps on the same edge.
    assign carry_out  = en & ~dn & (q == MAX);
    assign borrow_out = en &  dn & (q == 4'd0);

endmodule

// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - MM:SS BCD up/down timer; lap capture under STOPWATCH_LAP_EN
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int  CLK_DIV    = 100_000_000,
    parameter int  MIN_DIGITS = 2,
    localparam int W          = 4 * (2 + MIN_DIGITS)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         RUN,
    input  logic         MODE,
    input  logic         CLR,
    input  logic         LOAD,
    input  logic [W-1:0] LOAD_VAL,
    input  logic         LAP,
    output logic [W-1:0] DO,
    output logic         TICK,
    output logic         WRAP,
    output logic         DONE,
    output logic         LOAD_ERR,
    output logic [W-1:0] LAP_DO
);

    localparam int NDIG = 2 + MIN_DIGITS;
    localparam int PW   = $clog2(CLK_DIV);

    logic [PW-1:0]   presc;
    logic            halted, advance, term, load_ok, tick, dig_load;
    logic [NDIG-1:0] dig_en, carry, borrow;
    logic            unused_borrow_top;

    assign halted   = DONE & (MODE == MODE_DN);
    assign advance  = RUN & ~halted;
    assign term     = advance & (presc == PW'(CLK_DIV - 1));
    assign load_ok  = bcd_word_valid(64'(LOAD_VAL), NDIG);
    assign tick     = term & ~RST & ~CLR & ~LOAD;
    assign dig_load = ~CLR & LOAD & load_ok;

    // A rejected LOAD still freezes the prescaler for that cycle.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            presc <= '0;
        end else if (LOAD) begin
            if (load_ok) presc <= '0;
        end else if (advance) begin
            presc <= term ? '0 : presc + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            DONE <= 1'b0;
        end else if (LOAD && load_ok) begin
            DONE <= 1'b0;
        end else if (tick && MODE == MODE_DN && DO == W'(1)) begin
            DONE <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) LOAD_ERR <= 1'b0;
        else     LOAD_ERR <= LOAD & ~CLR & ~load_ok;
    end

    assign dig_en[0] = tick;
    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        if (g > 0) begin : g_chain
            assign dig_en[g] = carry[g-1] | borrow[g-1];
        end
        bcd_digit_cnt #(.MOD(digit_mod(g))) u_digit (
            .CLK        (CLK),
            .RST        (RST),
            .en         (dig_en[g]),
            .dn         (MODE),
            .clr        (CLR),
            .load       (dig_load),
            .load_val   (LOAD_VAL[g*4 +: 4]),
            .q          (DO[g*4 +: 4]),
            .carry_out  (carry[g]),
            .borrow_out (borrow[g])
        );
    end

    // Down-count wrap from zero is deliberately silent; only the up carry flags WRAP.
    assign TICK              = tick;
    assign WRAP              = carry[NDIG-1];
    assign unused_borrow_top = borrow[NDIG-1];

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge CLK) begin
        if (RST)      LAP_DO <= '0;
        else if (LAP) LAP_DO <= DO;
    end
`else
    logic unused_lap;
    assign unused_lap = LAP;
    assign LAP_DO     = '0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb/tb_bcd_stopwatch.sv - directed scoreboard bench for bcd_stopwatch (CLK_DIV=4, MIN_DIGITS=2)
module tb_bcd_stopwatch;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RUN = 1'b0, MODE = 1'b0, CLR = 1'b0, LOAD = 1'b0, LAP = 1'b0;
    logic [15:0] LOAD_VAL = '0;
    logic [15:0] DO, LAP_DO;
    logic        TICK, WRAP, DONE, LOAD_ERR;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } sb_item_t;
    sb_item_t sb_q[$];

    bcd_stopwatch #(.CLK_DIV(4), .MIN_DIGITS(2)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .MODE(MODE), .CLR(CLR), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL), .LAP(LAP), .DO(DO), .TICK(TICK), .WRAP(WRAP),
        .DONE(DONE), .LOAD_ERR(LOAD_ERR), .LAP_DO(LAP_DO)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input logic [15:0] val);
        sb_item_t it;
        it.tag = tag;
        it.val = val;
        sb_q.push_back(it);
    endtask

    task automatic sb_pop_check();
        sb_item_t it;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            it = sb_q.pop_front();
            check(it.tag, 32'(DO), 32'(it.val));
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Leaves time inside the cycle where TICK is high (not yet consumed).
    task automatic wait_tick(input int bound, output int waited);
        waited = 0;
        while (TICK !== 1'b1 && waited < bound) begin
            cyc();
            waited++;
        end
        if (TICK !== 1'b1) check("tick_timeout", 32'(TICK), 32'd1);
    endtask

    task automatic run_ticks(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            wait_tick(8, w);
            cyc();
        end
    endtask

    task automatic do_load(input logic [15:0] val);
        LOAD_VAL = val;
        LOAD = 1'b1;
        cyc();
        LOAD = 1'b0;
    endtask

    initial begin
        int w;
        int nticks;
        logic [15:0] exp_lap;

        cyc();
        cyc();
        check("rst_do", 32'(DO), 32'h0);
        check("rst_flags", {28'd0, TICK, WRAP, DONE, LOAD_ERR}, 32'h0);
        check("rst_lap", 32'(LAP_DO), 32'h0);

        RST = 1'b0;
        RUN = 1'b1;
        MODE = 1'b0;
        wait_tick(8, w);
        check("first_tick_latency", 32'(w), 32'd3);
        cyc();
        check("tick_one_cycle", 32'(TICK), 32'd0);
        sb_push("up_tick1", 16'h0001);
        sb_pop_check();
        wait_tick(8, w);
        check("tick_period", 32'(w), 32'd3);
        cyc();
        sb_push("up_60", 16'h0100);
        sb_push("up_600", 16'h1000);
        run_ticks(58);
        sb_pop_check();
        run_ticks(540);
        sb_pop_check();

        do_load(16'h9958);
        sb_push("load_9958", 16'h9958);
        sb_pop_check();
        wait_tick(8, w);
        check("no_wrap_9958", 32'(WRAP), 32'd0);
        cyc();
        sb_push("up_9959", 16'h9959);
        sb_pop_check();
        wait_tick(8, w);
        check("wrap_with_tick", {30'd0, TICK, WRAP}, 32'h3);
        cyc();
        sb_push("wrap_0000", 16'h0000);
        sb_pop_check();
        check("wrap_one_cycle", 32'(WRAP), 32'd0);

        MODE = 1'b1;
        do_load(16'h0002);
        sb_push("dn_0001", 16'h0001);
        sb_push("dn_0000", 16'h0000);
        run_ticks(1);
        sb_pop_check();
        run_ticks(1);
        sb_pop_check();
        check("done_set", 32'(DONE), 32'd1);
        nticks = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (TICK === 1'b1) nticks++;
        end
        check("halted_no_tick", 32'(nticks), 32'd0);
        check("halted_do", 32'(DO), 32'h0);
        MODE = 1'b0;
        wait_tick(8, w);
        check("resume_up_latency", 32'(w), 32'd3);
        cyc();
        check("resume_up_do", 32'(DO), 32'h0001);
        check("done_sticky", 32'(DONE), 32'd1);

        CLR = 1'b1;
        cyc();
        CLR = 1'b0;
        check("clr_done", 32'(DONE), 32'd0);
        cyc();
        cyc();
        RUN = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        check("pause_no_tick", 32'(TICK), 32'd0);
        RUN = 1'b1;
        wait_tick(8, w);
        check("pause_resume_latency", 32'(w), 32'd1);
        cyc();
        check("pause_resume_do", 32'(DO), 32'h0001);

        do_load(16'h0070);
        check("load_err_pulse", 32'(LOAD_ERR), 32'd1);
        check("load_err_do", 32'(DO), 32'h0001);
        cyc();
        check("load_err_once", 32'(LOAD_ERR), 32'd0);

        wait_tick(8, w);
        CLR = 1'b1;
        #1;
        check("clr_kills_tick", 32'(TICK), 32'd0);
        cyc();
        CLR = 1'b0;
        check("clr_term_do", 32'(DO), 32'h0);
        wait_tick(8, w);
        check("clr_presc_zero", 32'(w), 32'd3);
        cyc();

        CLR = 1'b1;
        cyc();
        CLR = 1'b0;
        MODE = 1'b1;
        wait_tick(8, w);
        check("dn_from_zero_no_wrap", 32'(WRAP), 32'd0);
        cyc();
        check("dn_from_zero_do", 32'(DO), 32'h9959);
        check("dn_from_zero_done", 32'(DONE), 32'd0);

        MODE = 1'b0;
        do_load(16'h0123);
        LAP = 1'b1;
        cyc();
        LAP = 1'b0;
`ifdef STOPWATCH_LAP_EN
        exp_lap = 16'h0123;
`else
        exp_lap = 16'h0000;
`endif
        check("lap_capture", 32'(LAP_DO), 32'(exp_lap));
        run_ticks(1);
        check("lap_do_runs", 32'(DO), 32'h0124);
        check("lap_hold", 32'(LAP_DO), 32'(exp_lap));
        wait_tick(8, w);
        LAP = 1'b1;
        cyc();
        LAP = 1'b0;
`ifdef STOPWATCH_LAP_EN
        exp_lap = 16'h0124;
`endif
        check("lap_pre_update", 32'(LAP_DO), 32'(exp_lap));
        check("lap_tick_do", 32'(DO), 32'h0125);
        CLR = 1'b1;
        cyc();
        CLR = 1'b0;
        check("lap_survives_clr", 32'(LAP_DO), 32'(exp_lap));
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        check("lap_rst", 32'(LAP_DO), 32'h0);
        check("final_rst_do", 32'(DO), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
